// File: rtl/timer_ctrl_n_if.sv
// Register bus between the pinmux reg master and timer_ctrl_n.
// The master holds reg_cs until the slave answers with a one-cycle reg_ack.
interface timer_ctrl_n_if #(
   parameter int unsigned ADDR_W = 4
) ();
   logic              reg_cs;
   logic              reg_wr;
   logic [ADDR_W-1:0] reg_addr;
   logic [31:0]       reg_wdata;
   logic [3:0]        reg_be;
   logic [31:0]       reg_rdata;
   logic              reg_ack;

   modport master (
      output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
      input  reg_rdata, reg_ack
   );

   modport slave (
      input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
      output reg_rdata, reg_ack
   );
endinterface

// File: rtl/timer_ctrl_n.sv
// Multi-channel one-shot/periodic down-counter timers with their register slave.
// Channels tick on a shared programmable 1us prescaler or directly on mclk.
module timer_ctrl_n #(
   parameter int unsigned NUM_TIMER = 3,
   parameter int unsigned CNT_W     = 19,
   parameter int unsigned ADDR_W    = 4
) (
   input  logic                 mclk,
   input  logic                 h_reset,
   timer_ctrl_n_if.slave        bus,
   output logic [NUM_TIMER-1:0] timer_intr,
   output logic                 timer_irq
);

   localparam int unsigned DIV_W  = 10;
   localparam int unsigned CFG_W  = CNT_W + 3;
   localparam int unsigned EN_B   = CNT_W;
   localparam int unsigned MODE_B = CNT_W + 1;
   localparam int unsigned SEL_B  = CNT_W + 2;

   logic [DIV_W-1:0]     div_q, div_d;
   logic [DIV_W-1:0]     pre_q, pre_d;
   logic [NUM_TIMER-1:0] stat_q, stat_d;
   logic [NUM_TIMER-1:0] ien_q, ien_d;
   logic [CFG_W-1:0]     cfg_q [NUM_TIMER];
   logic [CFG_W-1:0]     cfg_d [NUM_TIMER];
   logic [CNT_W-1:0]     cnt_q [NUM_TIMER];
   logic [CNT_W-1:0]     cnt_d [NUM_TIMER];
   logic                 ack_q, ack_d;
   logic [31:0]          rdata_q, rdata_d;

   logic                 commit;
   logic                 wr_commit;
   logic                 tick_1us;
   logic [NUM_TIMER-1:0] hw_set;
   logic [NUM_TIMER-1:0] w1c;
   logic [CFG_W-1:0]     wval;
   logic [31:0]          rd_val;

   assign commit    = bus.reg_cs & ~ack_q;
   assign wr_commit = commit & bus.reg_wr;
   assign tick_1us  = (pre_q == div_q);

   // Next-state for prescaler, channels, status and bus response
   always_comb begin
      div_d   = div_q;
      pre_d   = tick_1us ? '0 : pre_q + DIV_W'(1);
      stat_d  = stat_q;
      ien_d   = ien_q;
      cfg_d   = cfg_q;
      cnt_d   = cnt_q;
      ack_d   = commit;
      rdata_d = rdata_q;
      hw_set  = '0;
      w1c     = '0;
      wval    = '0;
      rd_val  = '0;

      for (int ch = 0; ch < NUM_TIMER; ch++) begin
         if (cfg_q[ch][EN_B] && (cfg_q[ch][SEL_B] || tick_1us)) begin
            if (cnt_q[ch] == '0) begin
               hw_set[ch] = 1'b1;
               if (cfg_q[ch][MODE_B]) cnt_d[ch] = cfg_q[ch][CNT_W-1:0];
               else                   cfg_d[ch][EN_B] = 1'b0;
            end else begin
               cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
            end
         end
      end

      // CPU writes are applied after the hardware updates so they take priority
      if (wr_commit) begin
         if (bus.reg_addr == ADDR_W'(0)) begin
            for (int b = 0; b < DIV_W; b++)
               if (bus.reg_be[b/8]) div_d[b] = bus.reg_wdata[b];
            pre_d = '0;
         end
         if (bus.reg_addr == ADDR_W'(1)) begin
            for (int b = 0; b < NUM_TIMER; b++)
               w1c[b] = bus.reg_be[b/8] & bus.reg_wdata[b];
         end
         if (bus.reg_addr == ADDR_W'(2)) begin
            for (int b = 0; b < NUM_TIMER; b++)
               if (bus.reg_be[b/8]) ien_d[b] = bus.reg_wdata[b];
         end
         for (int ch = 0; ch < NUM_TIMER; ch++) begin
            if (bus.reg_addr == ADDR_W'(3 + ch)) begin
               wval = cfg_q[ch];
               for (int b = 0; b < CFG_W; b++)
                  if (bus.reg_be[b/8]) wval[b] = bus.reg_wdata[b];
               cfg_d[ch] = wval;
               if (wval[EN_B]) cnt_d[ch] = wval[CNT_W-1:0];
            end
         end
      end

      // A hardware set in the same cycle as a W1C keeps the bit
      stat_d = (stat_q & ~w1c) | hw_set;

      if (bus.reg_addr == ADDR_W'(0)) rd_val = 32'(div_q);
      if (bus.reg_addr == ADDR_W'(1)) rd_val = 32'(stat_q);
      if (bus.reg_addr == ADDR_W'(2)) rd_val = 32'(ien_q);
      for (int ch = 0; ch < NUM_TIMER; ch++) begin
         if (bus.reg_addr == ADDR_W'(3 + ch))             rd_val = 32'(cfg_q[ch]);
         if (bus.reg_addr == ADDR_W'(3 + NUM_TIMER + ch)) rd_val = 32'(cnt_q[ch]);
      end
      if (commit) rdata_d = rd_val;
   end

   always_ff @(posedge mclk) begin
      if (h_reset) begin
         div_q   <= '0;
         pre_q   <= '0;
         stat_q  <= '0;
         ien_q   <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         for (int ch = 0; ch < NUM_TIMER; ch++) begin
            cfg_q[ch] <= '0;
            cnt_q[ch] <= '0;
         end
      end else begin
         div_q   <= div_d;
         pre_q   <= pre_d;
         stat_q  <= stat_d;
         ien_q   <= ien_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         for (int ch = 0; ch < NUM_TIMER; ch++) begin
            cfg_q[ch] <= cfg_d[ch];
            cnt_q[ch] <= cnt_d[ch];
         end
      end
   end

   assign bus.reg_ack   = ack_q;
   assign bus.reg_rdata = rdata_q;
   assign timer_intr    = stat_q & ien_q;
   assign timer_irq     = |timer_intr;

endmodule

// File: tb/tb_timer_ctrl_n.sv
// Scoreboarded bench for timer_ctrl_n: read expectations are queued at issue
// and compared by a monitor when reg_ack returns the data.
module tb_timer_ctrl_n;

   localparam int unsigned NUM_TIMER = 3;
   localparam int unsigned CNT_W     = 19;
   localparam int unsigned ADDR_W    = 4;

   logic                 mclk = 1'b0;
   logic                 h_reset;
   logic [NUM_TIMER-1:0] timer_intr;
   logic                 timer_irq;

   timer_ctrl_n_if #(.ADDR_W(ADDR_W)) bus ();

   timer_ctrl_n #(
      .NUM_TIMER (NUM_TIMER),
      .CNT_W     (CNT_W),
      .ADDR_W    (ADDR_W)
   ) dut (
      .mclk       (mclk),
      .h_reset    (h_reset),
      .bus        (bus),
      .timer_intr (timer_intr),
      .timer_irq  (timer_irq)
   );

   always #5 mclk = ~mclk;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   logic        last_wr  = 1'b0;
   logic [31:0] exp_q [$];
   string       tag_q [$];
   int          t0, t1, tc;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   always @(posedge mclk) begin
      cyc <= cyc + 1;
      if (bus.reg_cs && !bus.reg_ack) last_wr <= bus.reg_wr;
   end

   // Scoreboard: every read ack pops one queued expectation
   always @(negedge mclk) begin
      if (bus.reg_ack && !last_wr) begin
         if (exp_q.size() == 0) chk_eq("sb_empty", 32'(exp_q.size()), 32'd1);
         else chk_eq(tag_q.pop_front(), bus.reg_rdata, exp_q.pop_front());
      end
   end

   task automatic xfer(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       input logic [3:0] be, output int ack_cyc);
      int n = 0;
      @(negedge mclk);
      bus.reg_cs    = 1'b1;
      bus.reg_wr    = w;
      bus.reg_addr  = a;
      bus.reg_wdata = d;
      bus.reg_be    = be;
      do begin
         @(negedge mclk);
         n++;
      end while (!bus.reg_ack && n < 8);
      ack_cyc = cyc;
      chk_eq("ack_latency", 32'(n), 32'd1);
      bus.reg_cs = 1'b0;
      @(negedge mclk);
      chk_eq("ack_pulse", 32'(bus.reg_ack), 32'd0);
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
      int unused_cyc;
      xfer(1'b1, a, d, be, unused_cyc);
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
      int unused_cyc;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      xfer(1'b0, a, 32'h0, 4'hF, unused_cyc);
   endtask

   task automatic wait_intr(input int bitn, output int at);
      int n = 0;
      while (!timer_intr[bitn] && n < 200) begin
         @(negedge mclk);
         n++;
      end
      at = cyc;
      if (!timer_intr[bitn]) chk_eq("intr_timeout", 32'(timer_intr[bitn]), 32'd1);
   endtask

   initial begin
      h_reset       = 1'b1;
      bus.reg_cs    = 1'b0;
      bus.reg_wr    = 1'b0;
      bus.reg_addr  = '0;
      bus.reg_wdata = '0;
      bus.reg_be    = '0;
      repeat (3) @(negedge mclk);
      chk_eq("rst_ack",   32'(bus.reg_ack), 32'd0);
      chk_eq("rst_rdata", bus.reg_rdata,    32'd0);
      chk_eq("rst_intr",  32'(timer_intr),  32'd0);
      chk_eq("rst_irq",   32'(timer_irq),   32'd0);
      h_reset = 1'b0;

      for (int a = 0; a < 9; a++) rd(ADDR_W'(a), 32'h0, "rst_reg");
      rd(4'hF, 32'h0, "unmapped_rd");

      // Periodic, load 4 on a 10-cycle prescaler: 50-cycle expiry period
      wr(4'd0, 32'd9);
      rd(4'd0, 32'd9, "glbl_cfg");
      wr(4'd2, 32'd1);
      wr(4'd3, 32'h0018_0004);
      wait_intr(0, t0);
      chk_eq("periodic_irq", 32'(timer_irq), 32'd1);
      wr(4'd1, 32'd1);
      chk_eq("w1c_clears", 32'(timer_intr[0]), 32'd0);
      wait_intr(0, t1);
      chk_eq("period_50", 32'(t1 - t0), 32'd50);
      wr(4'd3, 32'h0);
      wr(4'd1, 32'd1);
      rd(4'd1, 32'd0, "stat_clr0");

      // One-shot, load 2 on mclk: expires 3 cycles after the load
      wr(4'd2, 32'd3);
      xfer(1'b1, 4'd4, 32'h0028_0002, 4'hF, tc);
      wait_intr(1, t1);
      chk_eq("oneshot_lat", 32'(t1 - tc), 32'd3);
      rd(4'd4, 32'h0020_0002, "oneshot_en_clr");
      rd(4'd7, 32'd0, "oneshot_cnt");
      wr(4'd2, 32'd1);
      chk_eq("mask_intr", 32'(timer_intr[1]), 32'd0);
      rd(4'd1, 32'd2, "mask_keeps_stat");
      wr(4'd1, 32'd2);
      repeat (20) @(negedge mclk);
      rd(4'd1, 32'd0, "oneshot_no_rearm");

      // Load-0 periodic on mclk expires every cycle, so W1C always collides with a set
      wr(4'd3, 32'h0038_0000);
      wr(4'd1, 32'd1);
      rd(4'd1, 32'd1, "w1c_vs_set");
      wr(4'd3, 32'h0);
      wr(4'd1, 32'd1);
      rd(4'd1, 32'd0, "w1c_clear");

      wr(4'd5, 32'hFFFF_FFFF, 4'b0001);
      rd(4'd5, 32'h0000_00FF, "be_cfg2");
      rd(4'd8, 32'd0, "be_no_load");

      // Slow prescaler keeps timer 0 at 3 while it is restarted
      wr(4'd0, 32'd1023);
      wr(4'd3, 32'h0018_0003);
      rd(4'd6, 32'd3, "cnt_before");
      wr(4'd3, 32'h0018_0064);
      rd(4'd6, 32'd100, "restart_cnt");
      rd(4'd1, 32'd0, "restart_no_stat");

      @(negedge mclk);
      bus.reg_cs   = 1'b1;
      bus.reg_wr   = 1'b0;
      bus.reg_addr = 4'd0;
      h_reset      = 1'b1;
      @(negedge mclk);
      chk_eq("rst_mid_ack", 32'(bus.reg_ack), 32'd0);
      bus.reg_cs = 1'b0;
      h_reset    = 1'b0;
      rd(4'd0, 32'd0, "rst_glbl");
      rd(4'd3, 32'd0, "rst_cfg0");
      rd(4'd6, 32'd0, "rst_cnt0");

      repeat (2) @(negedge mclk);
      chk_eq("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timer_ctrl_n.md
Name: timer_ctrl_n

Overview:
- Parametrised multi-channel timer: register slave plus the timer counters themselves, replacing the split config-register/timer-core arrangement in pinmux.
- Holds NUM_TIMER down-counters, each configurable as one-shot or periodic, ticking on a shared programmable 1us prescaler or directly on mclk.
- Provides per-channel sticky W1C interrupt status, interrupt enables and readable live counts.
- Sits on the pinmux reg bus beside the other pinmux register blocks; drives interrupt lines to the global interrupt aggregator.

Parameters:
- NUM_TIMER, 3, number of timer channels (1..8).
- CNT_W, 19, counter/load width in bits (1..28).
- ADDR_W, 4, reg_addr width; must satisfy 2^ADDR_W >= 3+2*NUM_TIMER.

Ports:
- mclk  in  1  system clock; only clock.
- h_reset  in  1  reset, synchronous, active-high.
- reg_cs  in  1  register access select; held until reg_ack.
- reg_wr  in  1  1=write, 0=read.
- reg_addr  in  ADDR_W  word address.
- reg_wdata  in  32  write data.
- reg_be  in  4  byte enables for writes.
- reg_rdata  out  32  read data, valid with reg_ack.
- reg_ack  out  1  single-cycle access acknowledge.
- timer_intr  out  NUM_TIMER  per-channel interrupt, INTR_STAT & INTR_EN.
- timer_irq  out  1  OR of timer_intr.

Behaviour:
- Reset, synchronous, h_reset=1 at a mclk edge: all registers, counters, prescaler, reg_rdata, reg_ack, timer_intr and timer_irq go to 0.
- Bus handshake:
  - Access commits on the cycle with reg_cs=1 and reg_ack=0.
  - reg_ack=1 on the next cycle, for exactly one cycle; reg_rdata is captured at commit.
  - Back-to-back accesses take 2 cycles each.
  - A write commits once per access: byte lanes with reg_be[n]=1 update; unmapped or read-only bits are ignored.
- Register map (word address):
  - 0 GLBL_CFG: [9:0] pulse_1us divider; RW.
  - 1 INTR_STAT: [NUM_TIMER-1:0] sticky status; W1C.
  - 2 INTR_EN: [NUM_TIMER-1:0]; RW.
  - 3+i TMR_CFG_i: [CNT_W-1:0] load; [CNT_W] enable; [CNT_W+1] mode (0 one-shot, 1 periodic); [CNT_W+2] tick_sel (0 = 1us pulse, 1 = mclk); RW.
  - 3+NUM_TIMER+i TMR_CNT_i: [CNT_W-1:0] live count; RO.
  - Unmapped addresses read 0; writes to them are ignored.
- Prescaler:
  - 10-bit counter increments each mclk.
  - When it equals GLBL_CFG[9:0], a one-cycle tick_1us is emitted and the counter returns to 0; period is divider+1 cycles.
  - A write to GLBL_CFG clears the prescaler counter.
- Channel i:
  - A committed write to TMR_CFG_i that leaves enable=1 loads count_i <= new load value on the cycle after commit. This includes rewrites while running (restart).
  - Its tick is tick_1us when tick_sel=0, or every mclk when tick_sel=1. Ticks are evaluated only when enable=1; with enable=0 the count holds.
  - On a tick with count_i != 0: count_i decrements by 1.
  - On a tick with count_i == 0 (expiry):
    - INTR_STAT[i] is set.
    - periodic: count_i <= load.
    - one-shot: hardware clears enable; count stays 0.
  - Expiry period is load+1 ticks; load=0 periodic with tick_sel=1 expires every cycle.
- Simultaneous events:
  - Hardware set and W1C of the same INTR_STAT bit in one cycle: set wins.
  - A CPU write to TMR_CFG_i and a hardware enable-clear in the same cycle: the CPU write wins.
  - A load on the cycle after commit overrides any tick that cycle.
- Outputs:
  - timer_intr and timer_irq are combinational from the registered INTR_STAT/INTR_EN.
  - Clearing INTR_EN masks the output but preserves the status.
- Reset asserted mid-access drops reg_ack the next cycle; the access is lost.

Test Plan:
- Reset -> all outputs 0; read of addr 0..8 (default params) returns 0; read of addr 15 returns 0, reg_ack pulses 1 cycle.
- GLBL_CFG=9, TMR_CFG_0 = load 4, enable, periodic, tick_sel 0 -> INTR_STAT[0] sets every 50 mclk; with INTR_EN[0]=1, timer_intr[0]=1 and timer_irq=1.
- TMR_CFG_1 = load 2, one-shot, tick_sel 1 -> INTR_STAT[1] sets 3 cycles after load; TMR_CFG_1 enable bit reads 0; TMR_CNT_1 stays 0; no further expiry.
- Write INTR_STAT=1 on the exact expiry cycle of periodic load-0 mclk timer 0 -> bit remains 1; W1C on a non-expiry cycle -> bit clears to 0.
- Byte-enable write reg_be=4'b0001, wdata 0xFFFF_FFFF to TMR_CFG_2 -> only load[7:0]=0xFF; enable stays 0; count does not load.
- Rewrite TMR_CFG_0 = load 100 while running at count 3 -> TMR_CNT_0 reads 100 after ack; INTR_STAT[0] not set.
